// File: rtl/vds2431_defs.sv
// Shared definitions for the virtual DS2431 slave: ROM command codes, ROM ID size
// and the state encoding used by the ROM command handlers.
package vds2431_defs;

    localparam logic [7:0] READ_ROM     = 8'h33;
    localparam logic [7:0] MATCH_ROM    = 8'h55;
    localparam logic [7:0] SEARCH_ROM   = 8'hF0;
    localparam logic [7:0] SKIP_ROM     = 8'hCC;
    localparam logic [7:0] RESUME       = 8'hA5;
    localparam logic [7:0] OD_SKIP_ROM  = 8'h3C;
    localparam logic [7:0] OD_MATCH_ROM = 8'h69;

    localparam int ROM_ID_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } romCmdState_t;

endpackage

// File: rtl/posPulse.sv
// Rising-edge detector: one-cycle pulse when the input goes from 0 to 1.
module posPulse (
    input  logic clk,
    input  logic nRst,
    input  logic i,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) prev <= 1'b0;
        else       prev <= i;
    end

    assign pulse = i & ~prev;

endmodule

// File: rtl/virtual_ds2431_rom_match_rom.sv
// Match ROM (0x55) handler: receives BYTE_CNT bytes LSB byte first and compares them
// against romID. Optional VDS2431_MATCH_ROM_EARLY_ABORT_EN stops at the first mismatch.
//
// state | meaning
// IDLE  | no command running; cmdDone/romMatch hold the last result
// REQ   | raise ioTrig to request the next byte
// WAIT  | ioTrig held high until the transceiver reports the byte complete
// DONE  | publish cmdDone and romMatch, then return to IDLE
module virtual_ds2431_rom_match_rom
    import vds2431_defs::*;
#(
    parameter int BYTE_CNT = ROM_ID_BYTES,
    parameter int ID_WIDTH = 8 * BYTE_CNT
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic [ID_WIDTH-1:0] romID,
    input  logic                cmdRunTrig,
    input  logic [7:0]          recvDat,
    output logic                transTrig,
    output logic                nRxTx,
    input  logic                ByteTransDone,
    output logic                cmdDone,
    output logic                romMatch
);

    localparam int IDX_W = $clog2(BYTE_CNT) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_CNT - 1);

    romCmdState_t     state, stateNxt;
    logic [IDX_W-1:0] byteIdx, byteIdxNxt;
    logic             mismatch, mismatchNxt;
    logic             ioTrig, ioTrigNxt;
    logic             cmdDoneNxt, romMatchNxt;
    logic             cmdRunTrigPos, byteDonePos;
    logic [7:0]       idBytes [BYTE_CNT];
    logic             byteNe;

    posPulse uRunEdge  (.clk(clk), .nRst(nRst), .i(cmdRunTrig),    .pulse(cmdRunTrigPos));
    posPulse uDoneEdge (.clk(clk), .nRst(nRst), .i(ByteTransDone), .pulse(byteDonePos));
    posPulse uTrigEdge (.clk(clk), .nRst(nRst), .i(ioTrig),        .pulse(transTrig));

    for (genvar k = 0; k < BYTE_CNT; k++) begin : gIdBytes
        assign idBytes[k] = romID[8*k +: 8];
    end

    assign byteNe = (recvDat != idBytes[byteIdx[IDX_W-2:0]]);
    assign nRxTx  = 1'b0;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= IDLE;
            byteIdx  <= '0;
            mismatch <= 1'b0;
            ioTrig   <= 1'b0;
            cmdDone  <= 1'b0;
            romMatch <= 1'b0;
        end else begin
            state    <= stateNxt;
            byteIdx  <= byteIdxNxt;
            mismatch <= mismatchNxt;
            ioTrig   <= ioTrigNxt;
            cmdDone  <= cmdDoneNxt;
            romMatch <= romMatchNxt;
        end
    end

    always_comb begin
        stateNxt    = state;
        byteIdxNxt  = byteIdx;
        mismatchNxt = mismatch;
        ioTrigNxt   = ioTrig;
        cmdDoneNxt  = cmdDone;
        romMatchNxt = romMatch;

        // A (re)start wins over a byte completing in the same cycle; that byte is dropped.
        if (cmdRunTrigPos) begin
            stateNxt    = REQ;
            byteIdxNxt  = '0;
            mismatchNxt = 1'b0;
            ioTrigNxt   = 1'b0;
            cmdDoneNxt  = 1'b0;
            romMatchNxt = 1'b0;
        end else begin
            case (state)
                IDLE: ioTrigNxt = 1'b0;
                REQ: begin
                    ioTrigNxt = 1'b1;
                    stateNxt  = WAIT;
                end
                WAIT: begin
                    if (byteDonePos) begin
                        mismatchNxt = mismatch | byteNe;
                        ioTrigNxt   = 1'b0;
                        byteIdxNxt  = byteIdx + IDX_W'(1);
`ifdef VDS2431_MATCH_ROM_EARLY_ABORT_EN
                        if ((byteIdx == LAST_IDX) || byteNe) stateNxt = DONE;
                        else                                 stateNxt = REQ;
`else
                        if (byteIdx == LAST_IDX) stateNxt = DONE;
                        else                     stateNxt = REQ;
`endif
                    end
                end
                DONE: begin
                    cmdDoneNxt  = 1'b1;
                    romMatchNxt = ~mismatch;
                    ioTrigNxt   = 1'b0;
                    stateNxt    = IDLE;
                end
                default: stateNxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_virtual_ds2431_rom_match_rom.sv
// Directed bench for the Match ROM handler: vector table plus restart/reset/idle sequences.
module tb_virtual_ds2431_rom_match_rom;

    logic        clk, nRst, cmdRunTrig, ByteTransDone;
    logic        transTrig, nRxTx, cmdDone, romMatch;
    logic [63:0] romID;
    logic [7:0]  recvDat;

    int   nVec = 0;
    int   nMis = 0;
    int   nRxTxBad = 0;
    int   trigDouble = 0;
    int   trigCount = 0;
    logic trigPrev = 1'b0;

    localparam logic [63:0] ID_A = 64'h3C00_0012_3456_782D;
    localparam logic [63:0] ID_B = 64'h0123_4567_89AB_CDEF;

`ifdef VDS2431_MATCH_ROM_EARLY_ABORT_EN
    localparam int P_BYTE3 = 4;
    localparam int P_BYTE0 = 1;
`else
    localparam int P_BYTE3 = 8;
    localparam int P_BYTE0 = 8;
`endif

    typedef struct {
        string       name;
        logic [63:0] id;
        logic [63:0] sent;
        int          expPulses;
        logic        expMatch;
    } vec_t;

    vec_t vecs [6];

    virtual_ds2431_rom_match_rom dut (
        .clk(clk),
        .nRst(nRst),
        .romID(romID),
        .cmdRunTrig(cmdRunTrig),
        .recvDat(recvDat),
        .transTrig(transTrig),
        .nRxTx(nRxTx),
        .ByteTransDone(ByteTransDone),
        .cmdDone(cmdDone),
        .romMatch(romMatch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (nRxTx !== 1'b0) nRxTxBad++;
        if (transTrig === 1'b1) begin
            trigCount++;
            if (trigPrev === 1'b1) trigDouble++;
        end
        trigPrev = transTrig;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic startCmd();
        cmdRunTrig = 1'b1;
        @(negedge clk);
        cmdRunTrig = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        repeat (2) @(negedge clk);
        recvDat       = b;
        ByteTransDone = 1'b1;
        @(negedge clk);
        ByteTransDone = 1'b0;
    endtask

    task automatic waitTrig(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (transTrig === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Acts as the byte transceiver: answers every transTrig with the next byte of 'sent'.
    task automatic serve(input logic [63:0] sent, output int pulses, output bit timedOut);
        int cyc;
        int idx;
        pulses   = 0;
        cyc      = 0;
        timedOut = 1'b0;
        while (cmdDone !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (transTrig === 1'b1) begin
                pulses++;
                idx = (pulses <= 8) ? pulses - 1 : 0;
                sendByte(8'(sent >> (8 * idx)));
            end
        end
        if (cmdDone !== 1'b1) timedOut = 1'b1;
    endtask

    initial begin
        int  pulses;
        int  snap;
        bit  tmo;
        bit  ok;

        vecs[0] = '{"all_match",     ID_A, ID_A,                     8,       1'b1};
        vecs[1] = '{"byte3_bad",     ID_A, 64'h3C00_0012_3556_782D,  P_BYTE3, 1'b0};
        vecs[2] = '{"last_bad",      ID_A, 64'h3D00_0012_3456_782D,  8,       1'b0};
        vecs[3] = '{"first_bad",     ID_A, 64'h3C00_0012_3456_782E,  P_BYTE0, 1'b0};
        vecs[4] = '{"other_id",      ID_B, ID_B,                     8,       1'b1};
        vecs[5] = '{"all_bad",       ID_B, ID_A,                     P_BYTE0, 1'b0};

        nRst          = 1'b0;
        cmdRunTrig    = 1'b0;
        ByteTransDone = 1'b0;
        recvDat       = 8'h00;
        romID         = ID_A;
        repeat (3) @(negedge clk);
        check("rst_cmdDone",   cmdDone,   1'b0);
        check("rst_romMatch",  romMatch,  1'b0);
        check("rst_transTrig", transTrig, 1'b0);
        check("rst_nRxTx",     nRxTx,     1'b0);
        nRst = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            romID = vecs[v].id;
            startCmd();
            serve(vecs[v].sent, pulses, tmo);
            check({vecs[v].name, "_timeout"},  tmo,      1'b0);
            check({vecs[v].name, "_pulses"},   pulses,   vecs[v].expPulses);
            check({vecs[v].name, "_cmdDone"},  cmdDone,  1'b1);
            check({vecs[v].name, "_romMatch"}, romMatch, vecs[v].expMatch);
            repeat (3) @(negedge clk);
        end

        // First request latency, then restart coinciding with a byte completion.
        romID = ID_A;
        startCmd();
        check("lat_trig_n1", transTrig, 1'b0);
        @(negedge clk);
        check("lat_trig_n2", transTrig, 1'b1);
        sendByte(8'h2D);
        waitTrig(ok);
        sendByte(8'h78);
        waitTrig(ok);
        sendByte(8'h56);
        waitTrig(ok);
        check("restart_trig_seen", ok, 1'b1);
        repeat (2) @(negedge clk);
        recvDat       = 8'hFF;
        ByteTransDone = 1'b1;
        cmdRunTrig    = 1'b1;
        @(negedge clk);
        ByteTransDone = 1'b0;
        cmdRunTrig    = 1'b0;
        check("restart_cmdDone_clr", cmdDone, 1'b0);
        serve(ID_A, pulses, tmo);
        check("restart_timeout",  tmo,      1'b0);
        check("restart_pulses",   pulses,   8);
        check("restart_cmdDone",  cmdDone,  1'b1);
        check("restart_romMatch", romMatch, 1'b1);

        // ByteTransDone activity after DONE must be ignored.
        snap = trigCount;
        for (int t = 0; t < 5; t++) begin
            ByteTransDone = 1'b1;
            @(negedge clk);
            ByteTransDone = 1'b0;
            @(negedge clk);
        end
        check("done_idle_trigs",    trigCount - snap, 0);
        check("done_idle_cmdDone",  cmdDone,  1'b1);
        check("done_idle_romMatch", romMatch, 1'b1);

        // Asynchronous reset clears a held result without a clock edge.
        #1 nRst = 1'b0;
        #1;
        check("async_rst_cmdDone",  cmdDone,  1'b0);
        check("async_rst_romMatch", romMatch, 1'b0);
        @(negedge clk);
        nRst = 1'b1;

        snap = trigCount;
        for (int t = 0; t < 5; t++) begin
            ByteTransDone = 1'b1;
            @(negedge clk);
            ByteTransDone = 1'b0;
            @(negedge clk);
        end
        check("idle_trigs",   trigCount - snap, 0);
        check("idle_cmdDone", cmdDone, 1'b0);

        // Reset in the middle of the sixth byte request.
        startCmd();
        for (int b = 0; b < 5; b++) begin
            waitTrig(ok);
            sendByte(8'(ID_A >> (8 * b)));
        end
        waitTrig(ok);
        check("midrst_trig_pre", transTrig, 1'b1);
        #1 nRst = 1'b0;
        #1;
        check("midrst_transTrig", transTrig, 1'b0);
        check("midrst_cmdDone",   cmdDone,   1'b0);
        check("midrst_romMatch",  romMatch,  1'b0);
        @(negedge clk);
        nRst = 1'b1;
        snap = trigCount;
        repeat (20) @(negedge clk);
        check("midrst_quiet_trigs", trigCount - snap, 0);
        check("midrst_quiet_done",  cmdDone, 1'b0);

        startCmd();
        serve(ID_A, pulses, tmo);
        check("recover_timeout",  tmo,      1'b0);
        check("recover_pulses",   pulses,   8);
        check("recover_romMatch", romMatch, 1'b1);

        check("nRxTx_always_0",   nRxTxBad,   0);
        check("transTrig_1cycle", trigDouble, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
